// File: rtl/message_overlay.sv
// message_overlay: two-stage pixel pipeline that overlays a scaled 20x20 glyph message with per-state colour and blinking
module message_overlay #(
  parameter int X0 = 240,
  parameter int Y0 = 160,
  parameter int SCALE_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic [1:0] game_state,
  input  logic       word_bit,
  output logic [4:0] row,
  output logic [4:0] col,
  output logic [1:0] select,
  output logic       overlay_on,
  output logic [2:0] overlay_rgb
);
  localparam int W = 20 << SCALE_LOG2;
  localparam logic [10:0] XL = 11'(X0);
  localparam logic [10:0] XH = 11'(X0 + W);
  localparam logic [10:0] YL = 11'(Y0);
  localparam logic [10:0] YH = 11'(Y0 + W);
  logic [9:0] dx, dy;
  logic       in_win, in_win_q, frame_start, visible_msg, lit;
  logic [5:0] frame_cnt;
  logic [2:0] rgb;
  // window test, cell offsets, and message visibility/colour from the latched selector
  always_comb begin
    in_win = video_on && {1'b0, pixel_x} >= XL && {1'b0, pixel_x} < XH && {1'b0, pixel_y} >= YL && {1'b0, pixel_y} < YH;
    dx = pixel_x - XL[9:0];
    dy = pixel_y - YL[9:0];
    frame_start = pixel_tick && pixel_x == 10'd0 && pixel_y == 10'd0;
    visible_msg = select == 2'b10 ? 1'b0 : select == 2'b00 ? ~frame_cnt[5] : 1'b1;
    rgb = select == 2'b00 ? 3'b111 : select == 2'b01 ? 3'b100 : select == 2'b11 ? 3'b010 : 3'b000;
    lit = in_win_q ? (word_bit & visible_msg) : 1'b0;
  end
  // stage 1 captures window membership and glyph cell, stage 2 the lit pixel and its colour
  always_ff @(posedge clk) begin
    if (rst) begin
      in_win_q <= 1'b0;
      row <= '0;
      col <= '0;
      overlay_on <= 1'b0;
      overlay_rgb <= '0;
    end else if (pixel_tick) begin
      in_win_q <= in_win;
      row <= in_win ? 5'(dy >> SCALE_LOG2) : 5'd0;
      col <= in_win ? 5'(dx >> SCALE_LOG2) : 5'd0;
      overlay_on <= lit;
      overlay_rgb <= lit ? rgb : 3'b000;
    end
  end
  // message selector and blink counter change only at frame start; a new message restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      select <= 2'b10;
      frame_cnt <= '0;
    end else if (frame_start) begin
      select <= game_state;
      frame_cnt <= game_state != select ? 6'd0 : frame_cnt + 6'd1;
    end
  end
endmodule

// File: tb/tb_message_overlay.sv
// tb_message_overlay: directed checks of window mapping, latency, blinking, message switching, freeze and reset
module tb_message_overlay;
  logic       clk = 0, rst = 1, pixel_tick = 0, video_on = 1, word_bit;
  logic [9:0] pixel_x = 0, pixel_y = 0;
  logic [1:0] game_state = 2'b00, select;
  logic [4:0] row, col;
  logic       overlay_on;
  logic [2:0] overlay_rgb;
  int checks = 0, errors = 0;

  message_overlay dut (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .game_state(game_state), .word_bit(word_bit), .row(row), .col(col),
    .select(select), .overlay_on(overlay_on), .overlay_rgb(overlay_rgb)
  );

  always #5 clk = ~clk;
  // glyph ROM stand-in: odd columns lit; always lit while playing so a leak would show
  assign word_bit = select == 2'b10 ? 1'b1 : col[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int x, input int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    pixel_tick = 1;
    @(posedge clk);
    #1;
    pixel_tick = 0;
  endtask

  task automatic probe();
    tick(0, 0);
    tick(280, 168);
    tick(0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_row", row, 0);
    check("rst_col", col, 0);
    check("rst_sel", select, 2'b10);
    check("rst_on", overlay_on, 0);
    check("rst_rgb", overlay_rgb, 0);
    rst = 0;
    tick(0, 0);
    check("sel_wait", select, 2'b00);
    tick(240, 160);
    check("origin_row", row, 0);
    check("origin_col", col, 0);
    tick(0, 1);
    check("origin_on", overlay_on, 0);
    tick(280, 168);
    check("cell_row", row, 1);
    check("cell_col", col, 5);
    tick(0, 1);
    check("cell_on", overlay_on, 1);
    check("cell_rgb", overlay_rgb, 3'b111);
    tick(239, 160);
    check("xlo_win", dut.in_win_q, 0);
    check("xlo_col", col, 0);
    tick(400, 160);
    check("xhi_win", dut.in_win_q, 0);
    check("xhi_col", col, 0);
    tick(240, 159);
    check("ylo_win", dut.in_win_q, 0);
    tick(240, 319);
    check("yhi_row", row, 19);
    tick(399, 160);
    check("xedge_win", dut.in_win_q, 1);
    check("xedge_col", col, 19);
    tick(0, 1);
    check("xedge_on", overlay_on, 1);
    tick(280, 168);
    tick(281, 168);
    for (int i = 0; i < 10; i++) begin
      pixel_x = 10'(i * 37);
      pixel_y = 10'(i * 11);
      @(posedge clk);
    end
    #1;
    check("frz_row", row, 1);
    check("frz_col", col, 5);
    check("frz_on", overlay_on, 1);
    check("frz_rgb", overlay_rgb, 3'b111);
    for (int k = 1; k <= 64; k++) begin
      probe();
      check($sformatf("blink%0d", k), overlay_on, (k % 64) < 32);
    end
    game_state = 2'b01;
    tick(300, 200);
    check("mid_sel", select, 2'b00);
    tick(0, 0);
    check("lose_sel", select, 2'b01);
    check("lose_cnt", dut.frame_cnt, 0);
    for (int k = 1; k <= 40; k++) begin
      probe();
      check($sformatf("lose_on%0d", k), overlay_on, 1);
      check($sformatf("lose_rgb%0d", k), overlay_rgb, 3'b100);
    end
    game_state = 2'b11;
    probe();
    check("win_on", overlay_on, 1);
    check("win_rgb", overlay_rgb, 3'b010);
    game_state = 2'b10;
    tick(0, 0);
    check("play_sel", select, 2'b10);
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 20; c++) begin
        tick(240 + c * 8 + 3, 160 + r * 8 + 3);
        check("play_on", overlay_on, 0);
      end
    game_state = 2'b01;
    tick(0, 0);
    tick(280, 168);
    tick(281, 168);
    check("pre_rst_on", overlay_on, 1);
    rst = 1;
    @(posedge clk);
    #1;
    check("mrst_on", overlay_on, 0);
    check("mrst_sel", select, 2'b10);
    check("mrst_cnt", dut.frame_cnt, 0);
    check("mrst_row", row, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
